// File: rtl/addsub_accumulator_if.sv
// Handshake bundle for addsub_accumulator: burst control, operand input port
// and result output port.
interface addsub_accumulator_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] op_count;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_result;
  logic             out_ovfl;
  logic             busy;

  modport master (
    output start, op_count, in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_result, out_ovfl, busy
  );

  modport slave (
    input  start, op_count, in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_result, out_ovfl, busy
  );
endinterface

// File: rtl/addsub_accumulator.sv
// Burst accumulator around a signed 8-bit adder/subtractor: accepts op_count
// operand beats, then presents the final accumulator and a sticky overflow flag.
module addsub_accumulator #(
  parameter int unsigned CNT_W    = 8,
  parameter bit          SATURATE = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  addsub_accumulator_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             sticky_q, sticky_d;

  logic [7:0] b_eff;
  logic [7:0] sum;
  logic       ovf_raw;
  logic       ovf;
  logic       accept;

  // Adder/subtractor datapath: a = acc, b = in_data.
  always_comb begin
    b_eff   = bus.in_mode ? (~bus.in_data + 8'd1) : bus.in_data;
    sum     = acc_q + b_eff;
    ovf_raw = (acc_q[7] == b_eff[7]) && (sum[7] != acc_q[7]);
    // -128 has no 8-bit negation; subtracting it overflows iff acc is non-negative
    if (bus.in_mode && (bus.in_data == 8'h80)) begin
      ovf = ~acc_q[7];
    end else begin
      ovf = ovf_raw;
    end
  end

  assign accept = (state_q == StRun) && bus.in_valid;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    sticky_d = sticky_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d    = '0;
          sticky_d = 1'b0;
          rem_d    = bus.op_count;
          state_d  = (bus.op_count != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (accept) begin
          if (SATURATE && ovf) begin
            acc_d = acc_q[7] ? 8'h80 : 8'h7F;
          end else begin
            acc_d = sum;
          end
          sticky_d = sticky_q | ovf;
          rem_d    = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      rem_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready   = (state_q == StRun);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.out_result = (state_q == StDone) ? acc_q : 8'h00;
  assign bus.out_ovfl   = (state_q == StDone) ? sticky_q : 1'b0;
  assign bus.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_addsub_accumulator.sv
// Bench for addsub_accumulator: a wrapping and a saturating instance share the
// same stimulus; a reference model fills a scoreboard checked at each result.
module tb_addsub_accumulator;
  logic clk;
  logic rst;

  addsub_accumulator_if #(.CNT_W(8)) bus_w ();
  addsub_accumulator_if #(.CNT_W(8)) bus_s ();

  addsub_accumulator #(.CNT_W(8), .SATURATE(1'b0)) u_dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w.slave)
  );

  addsub_accumulator #(.CNT_W(8), .SATURATE(1'b1)) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  typedef struct packed {
    logic [7:0] rw;
    logic [7:0] rs;
    logic       ow;
    logic       os;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_acc_w, m_acc_s;
  logic       m_st_w, m_st_s;
  int         m_rem;
  int         vectors = 0;
  int         miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [7:0] cnt, input logic vld,
                       input logic [7:0] d, input logic m, input logic ordy);
    bus_w.start = st;   bus_s.start = st;
    bus_w.op_count = cnt; bus_s.op_count = cnt;
    bus_w.in_valid = vld; bus_s.in_valid = vld;
    bus_w.in_data = d;  bus_s.in_data = d;
    bus_w.in_mode = m;  bus_s.in_mode = m;
    bus_w.out_ready = ordy; bus_s.out_ready = ordy;
  endtask

  // Reference model in signed integer arithmetic.
  task automatic model_beat(input logic [7:0] d, input logic m);
    int   a, b, r;
    exp_t e;
    b = $signed(d);
    a = $signed(m_acc_w);
    r = m ? a - b : a + b;
    if (r > 127 || r < -128) m_st_w = 1'b1;
    m_acc_w = r[7:0];
    a = $signed(m_acc_s);
    r = m ? a - b : a + b;
    if (r > 127) begin
      m_acc_s = 8'h7F; m_st_s = 1'b1;
    end else if (r < -128) begin
      m_acc_s = 8'h80; m_st_s = 1'b1;
    end else begin
      m_acc_s = r[7:0];
    end
    m_rem--;
    if (m_rem == 0) begin
      e.rw = m_acc_w; e.rs = m_acc_s; e.ow = m_st_w; e.os = m_st_s;
      sb.push_back(e);
    end
  endtask

  task automatic start_burst(input int n);
    exp_t e;
    drive(1'b1, 8'(n), 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    bus_w.start = 1'b0; bus_s.start = 1'b0;
    m_acc_w = 8'h00; m_acc_s = 8'h00; m_st_w = 1'b0; m_st_s = 1'b0; m_rem = n;
    if (n == 0) begin
      e = '0;
      sb.push_back(e);
    end else begin
      vectors++;
      if ({bus_w.in_ready, bus_s.in_ready, bus_w.busy, bus_s.busy, bus_w.out_valid,
           bus_s.out_valid} !== 6'b111100) begin
        miscompares++;
        $display("FAIL run_entry: rdy/busy/vld got %b need 111100",
                 {bus_w.in_ready, bus_s.in_ready, bus_w.busy, bus_s.busy,
                  bus_w.out_valid, bus_s.out_valid});
      end
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic m);
    drive(1'b0, 8'h00, 1'b1, d, m, 1'b0);
    vectors++;
    if ({bus_w.in_ready, bus_s.in_ready, bus_w.out_valid, bus_s.out_valid} !== 4'b1100) begin
      miscompares++;
      $display("FAIL beat_ready: rdy/vld got %b need 1100",
               {bus_w.in_ready, bus_s.in_ready, bus_w.out_valid, bus_s.out_valid});
    end
    tick();
    bus_w.in_valid = 1'b0; bus_s.in_valid = 1'b0;
    model_beat(d, m);
  endtask

  task automatic stall_cycle(input logic with_start);
    drive(with_start, 8'($urandom_range(0, 255)), 1'b0, 8'($urandom), 1'b0, 1'b0);
    tick();
    bus_w.start = 1'b0; bus_s.start = 1'b0;
    vectors++;
    if ({bus_w.in_ready, bus_s.in_ready, bus_w.out_valid, bus_s.out_valid} !== 4'b1100) begin
      miscompares++;
      $display("FAIL stall_hold: rdy/vld got %b need 1100",
               {bus_w.in_ready, bus_s.in_ready, bus_w.out_valid, bus_s.out_valid});
    end
  endtask

  task automatic get_result(input int hold, input logic start_at_ack);
    exp_t e;
    vectors++;
    if ({bus_w.out_valid, bus_s.out_valid, bus_w.in_ready, bus_s.in_ready, bus_w.busy,
         bus_s.busy} !== 6'b110011) begin
      miscompares++;
      $display("FAIL done_flags: vld/rdy/busy got %b need 110011",
               {bus_w.out_valid, bus_s.out_valid, bus_w.in_ready, bus_s.in_ready,
                bus_w.busy, bus_s.busy});
    end
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL scoreboard: got empty queue need one entry");
      return;
    end
    e = sb.pop_front();
    vectors++;
    if ({bus_w.out_result, bus_s.out_result, bus_w.out_ovfl, bus_s.out_ovfl} !== e) begin
      miscompares++;
      $display("FAIL result: wrap %h/%b sat %h/%b need wrap %h/%b sat %h/%b",
               bus_w.out_result, bus_w.out_ovfl, bus_s.out_result, bus_s.out_ovfl,
               e.rw, e.ow, e.rs, e.os);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      vectors++;
      if ({bus_w.out_valid, bus_s.out_valid, bus_w.out_result, bus_s.out_result,
           bus_w.out_ovfl, bus_s.out_ovfl} !== {2'b11, e}) begin
        miscompares++;
        $display("FAIL out_stable: wrap %h sat %h vld %b%b need wrap %h sat %h vld 11",
                 bus_w.out_result, bus_s.out_result, bus_w.out_valid, bus_s.out_valid,
                 e.rw, e.rs);
      end
    end
    drive(start_at_ack, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    vectors++;
    if ({bus_w.out_valid, bus_s.out_valid, bus_w.busy, bus_s.busy, bus_w.in_ready,
         bus_s.in_ready, bus_w.out_result, bus_s.out_result, bus_w.out_ovfl,
         bus_s.out_ovfl} !== 24'h0) begin
      miscompares++;
      $display("FAIL back_to_idle: vld %b%b busy %b%b res %h %h need all zero",
               bus_w.out_valid, bus_s.out_valid, bus_w.busy, bus_s.busy,
               bus_w.out_result, bus_s.out_result);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({bus_w.out_valid, bus_s.out_valid, bus_w.busy, bus_s.busy, bus_w.in_ready,
         bus_s.in_ready, bus_w.out_result, bus_s.out_result, bus_w.out_ovfl,
         bus_s.out_ovfl} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_state: outputs got nonzero need all zero");
    end
    rst = 1'b0;
    tick();
    // Mid-burst reset discards progress.
    start_burst(4);
    send_beat(8'd20, 1'b0);
    send_beat(8'd7, 1'b1);
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus_w.out_valid, bus_s.out_valid, bus_w.busy, bus_s.busy, bus_w.in_ready,
         bus_s.in_ready, bus_w.out_result, bus_s.out_result, bus_w.out_ovfl,
         bus_s.out_ovfl} !== 24'h0) begin
      miscompares++;
      $display("FAIL midburst_reset: vld %b%b busy %b%b rdy %b%b need all zero",
               bus_w.out_valid, bus_s.out_valid, bus_w.busy, bus_s.busy,
               bus_w.in_ready, bus_s.in_ready);
    end
    tick();
    rst = 1'b0;
    sb.delete();
    start_burst(1);
    send_beat(8'd5, 1'b0);
    get_result(0, 1'b0);
  endtask

  task automatic test_wrap_saturate();
    start_burst(3);
    send_beat(8'd100, 1'b0);
    send_beat(8'd50, 1'b0);
    send_beat(8'hE2, 1'b1);
    vectors++;
    if ({bus_w.out_result, bus_s.out_result, bus_w.out_ovfl, bus_s.out_ovfl} !==
        {8'hB4, 8'h7F, 2'b11}) begin
      miscompares++;
      $display("FAIL wrap_sat_const: wrap %h sat %h ovfl %b%b need wrap b4 sat 7f ovfl 11",
               bus_w.out_result, bus_s.out_result, bus_w.out_ovfl, bus_s.out_ovfl);
    end
    get_result(1, 1'b0);
  endtask

  task automatic test_neg128();
    start_burst(1);
    send_beat(8'h80, 1'b1);
    vectors++;
    if ({bus_w.out_result, bus_s.out_result, bus_w.out_ovfl, bus_s.out_ovfl} !==
        {8'h80, 8'h7F, 2'b11}) begin
      miscompares++;
      $display("FAIL neg128_const: wrap %h sat %h ovfl %b%b need wrap 80 sat 7f ovfl 11",
               bus_w.out_result, bus_s.out_result, bus_w.out_ovfl, bus_s.out_ovfl);
    end
    get_result(0, 1'b0);
    // Negative acc minus -128 stays in range: -100 + 128 = 28.
    start_burst(2);
    send_beat(8'h9C, 1'b0);
    send_beat(8'h80, 1'b1);
    get_result(0, 1'b0);
  endtask

  task automatic test_stalls();
    start_burst(3);
    send_beat(8'd10, 1'b0);
    stall_cycle(1'b0);
    send_beat(8'd3, 1'b1);
    stall_cycle(1'b1);
    send_beat(8'hF0, 1'b0);
    get_result(4, 1'b0);
  endtask

  task automatic test_zero_count();
    start_burst(0);
    drive(1'b1, 8'd5, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    get_result(1, 1'b1);
    tick();
    vectors++;
    if ({bus_w.busy, bus_s.busy, bus_w.out_valid, bus_s.out_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL ack_start_ignored: busy/vld got %b need 0000",
               {bus_w.busy, bus_s.busy, bus_w.out_valid, bus_s.out_valid});
    end
  endtask

  task automatic test_back_to_back();
    int n, left;
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(1, 6);
      start_burst(n);
      left = n;
      while (left > 0) begin
        if ($urandom_range(0, 2) == 0) begin
          stall_cycle(1'($urandom_range(0, 1)));
        end else begin
          send_beat(8'($urandom), 1'($urandom_range(0, 1)));
          left--;
        end
      end
      get_result($urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout need summary before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    test_reset();
    test_wrap_saturate();
    test_neg128();
    test_stalls();
    test_zero_count();
    test_back_to_back();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d queued results need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
